conv_bram_1d_sched: RTL and testbench



---
 rtl/conv_1d_pkg.sv | 21 ++
 rtl/vc_cycle_buffer.sv | 25 ++
 rtl/conv_bram_1d_sched.sv | 137 +++++++++++++
 tb/tb_conv_bram_1d_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_1d_pkg.sv
// Shared types and address helper for the 1-D BRAM convolution job scheduler.
package conv_1d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    NEXT,
    DONE
  } sched_state_t;

  // First filter-BRAM word for a (group, channel) pair; taps follow contiguously.
  function automatic int unsigned filt_base(input int unsigned grp_idx,
                                            input int unsigned ch_idx,
                                            input int unsigned img_d,
                                            input int unsigned filter_l);
    return (grp_idx * img_d + ch_idx) * filter_l;
  endfunction

endpackage

// File: rtl/vc_cycle_buffer.sv
// Fixed-latency register pipeline; output is the input delayed by DEPTH cycles.
module vc_cycle_buffer #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/conv_bram_1d_sched.sv
// Job scheduler: for each (filter group, input channel) pair loads the taps,
// starts one 1-D pass on the controller and waits for it to finish.
module conv_bram_1d_sched
  import conv_1d_pkg::*;
#(
  parameter int  FILTER_L = 3,
  parameter int  IMG_D    = 4,
  parameter int  RESULT_D = 8,
  parameter int  PAR_K    = 2,
  localparam int NUM_GROUPS      = RESULT_D / PAR_K,
  localparam int FILT_WORDS      = NUM_GROUPS * IMG_D * FILTER_L,
  localparam int FILT_ADDR_WIDTH = (FILT_WORDS > 1) ? $clog2(FILT_WORDS) : 1,
  localparam int TAP_W           = (FILTER_L > 1) ? $clog2(FILTER_L) : 1,
  localparam int CH_W            = (IMG_D > 1) ? $clog2(IMG_D) : 1,
  localparam int GRP_W           = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       job_val,
  output logic                       job_rdy,
  output logic [FILT_ADDR_WIDTH-1:0] filt_rdaddr,
  output logic                       filt_wren,
  output logic [TAP_W-1:0]           filt_tap,
  output logic                       pass_val,
  input  logic                       pass_rdy,
  input  logic                       pass_done,
  output logic [CH_W-1:0]            img_ch,
  output logic [GRP_W-1:0]           grp,
  output logic                       accum_en,
  output logic                       busy,
  output logic                       done
);

  if (FILTER_L < 1 || IMG_D < 1 || RESULT_D < 1 || PAR_K < 1 ||
      (RESULT_D % PAR_K) != 0) begin : g_bad_params
    $error("conv_bram_1d_sched: illegal parameter combination");
  end

  sched_state_t     state, state_n;
  logic [CH_W-1:0]  ch, ch_n;
  logic [GRP_W-1:0] grp_q, grp_n;
  logic [TAP_W-1:0] tap, tap_n;
  logic             rd_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ch    <= '0;
      grp_q <= '0;
      tap   <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      grp_q <= grp_n;
      tap   <= tap_n;
    end
  end

  always_comb begin
    state_n  = state;
    ch_n     = ch;
    grp_n    = grp_q;
    tap_n    = tap;
    job_rdy  = 1'b0;
    pass_val = 1'b0;
    done     = 1'b0;
    rd_valid = 1'b0;
    case (state)
      IDLE: begin
        job_rdy = 1'b1;
        if (job_val) begin
          ch_n    = '0;
          grp_n   = '0;
          tap_n   = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        rd_valid = 1'b1;
        if (tap == TAP_W'(FILTER_L - 1)) begin
          tap_n   = '0;
          state_n = START;
        end else begin
          tap_n = tap + TAP_W'(1);
        end
      end
      START: begin
        pass_val = 1'b1;
        if (pass_rdy) state_n = RUN;
      end
      RUN: begin
        if (pass_done) state_n = NEXT;
      end
      NEXT: begin
        if (ch < CH_W'(IMG_D - 1)) begin
          ch_n    = ch + CH_W'(1);
          state_n = LOAD;
        end else if (grp_q < GRP_W'(NUM_GROUPS - 1)) begin
          ch_n    = '0;
          grp_n   = grp_q + GRP_W'(1);
          state_n = LOAD;
        end else begin
          // Return indices to zero so the idle scheduler shows overwrite mode.
          ch_n    = '0;
          grp_n   = '0;
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign filt_rdaddr = rd_valid
    ? FILT_ADDR_WIDTH'(filt_base(32'(grp_q), 32'(ch), IMG_D, FILTER_L) + 32'(tap))
    : '0;

  // BRAM data arrives one cycle after the address, so the tap strobe lags to match.
  vc_cycle_buffer #(
    .WIDTH (TAP_W + 1),
    .DEPTH (1)
  ) u_tap_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({rd_valid, tap}),
    .q     ({filt_wren, filt_tap})
  );

  assign img_ch   = ch;
  assign grp      = grp_q;
  assign accum_en = (ch != '0);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_conv_bram_1d_sched.sv
// Directed bench for conv_bram_1d_sched with default parameters (4 groups x 4 channels).
module tb_conv_bram_1d_sched;

  localparam int FILTER_L   = 3;
  localparam int IMG_D      = 4;
  localparam int RESULT_D   = 8;
  localparam int PAR_K      = 2;
  localparam int NUM_GROUPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       job_val = 1'b0;
  logic       pass_rdy = 1'b1;
  logic       pass_done = 1'b0;
  logic       job_rdy;
  logic [5:0] filt_rdaddr;
  logic       filt_wren;
  logic [1:0] filt_tap;
  logic       pass_val;
  logic [1:0] img_ch;
  logic [1:0] grp;
  logic       accum_en;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  conv_bram_1d_sched #(
    .FILTER_L (FILTER_L),
    .IMG_D    (IMG_D),
    .RESULT_D (RESULT_D),
    .PAR_K    (PAR_K)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .job_val     (job_val),
    .job_rdy     (job_rdy),
    .filt_rdaddr (filt_rdaddr),
    .filt_wren   (filt_wren),
    .filt_tap    (filt_tap),
    .pass_val    (pass_val),
    .pass_rdy    (pass_rdy),
    .pass_done   (pass_done),
    .img_ch      (img_ch),
    .grp         (grp),
    .accum_en    (accum_en),
    .busy        (busy),
    .done        (done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Event counters for handshakes and completion pulses
  always @(posedge clk) begin
    if (!reset && pass_val && pass_rdy) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One (group, channel) pass starting at the negedge of its first LOAD cycle.
  // r: pass_done arrives r cycles after the handshake; bp: START cycles with pass_rdy low;
  // spur: pulse pass_done during LOAD.
  task automatic run_pass(input int g, input int c, input int r, input int bp, input int spur);
    int hs0;
    hs0 = hs_cnt;
    for (int t = 0; t < FILTER_L; t++) begin
      chk("load_addr", 32'(filt_rdaddr), 32'((g * IMG_D + c) * FILTER_L + t));
      chk("load_ch", 32'(img_ch), 32'(c));
      chk("load_grp", 32'(grp), 32'(g));
      chk("load_accum", 32'(accum_en), 32'(c != 0));
      chk("load_wren", 32'(filt_wren), 32'(t > 0));
      if (t > 0) chk("load_tap", 32'(filt_tap), 32'(t - 1));
      chk("load_pval", 32'(pass_val), 32'd0);
      chk("load_busy", 32'(busy), 32'd1);
      pass_done = (spur != 0 && t == 1);
      if (t == FILTER_L - 1 && bp > 0) pass_rdy = 1'b0;
      step();
    end
    pass_done = 1'b0;
    chk("start_wren", 32'(filt_wren), 32'd1);
    chk("start_tap", 32'(filt_tap), 32'(FILTER_L - 1));
    for (int i = 0; i < bp; i++) begin
      chk("bp_pval", 32'(pass_val), 32'd1);
      chk("bp_ch", 32'(img_ch), 32'(c));
      chk("bp_grp", 32'(grp), 32'(g));
      chk("bp_accum", 32'(accum_en), 32'(c != 0));
      step();
    end
    pass_rdy = 1'b1;
    chk("start_pval", 32'(pass_val), 32'd1);
    step();
    for (int i = 1; i < r; i++) begin
      chk("run_pval", 32'(pass_val), 32'd0);
      chk("run_wren", 32'(filt_wren), 32'd0);
      chk("run_ch", 32'(img_ch), 32'(c));
      chk("run_grp", 32'(grp), 32'(g));
      step();
    end
    pass_done = 1'b1;
    chk("run_last_pval", 32'(pass_val), 32'd0);
    step();
    pass_done = 1'b0;
    chk("next_ch", 32'(img_ch), 32'(c));
    chk("next_grp", 32'(grp), 32'(g));
    chk("next_accum", 32'(accum_en), 32'(c != 0));
    chk("next_done", 32'(done), 32'd0);
    chk("next_busy", 32'(busy), 32'd1);
    step();
    chk("pass_handshakes", 32'(hs_cnt - hs0), 32'd1);
  endtask

  initial begin
    // Reset held
    reset = 1'b1;
    repeat (3) step();
    chk("rst_job_rdy", 32'(job_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wren", 32'(filt_wren), 32'd0);
    chk("rst_pval", 32'(pass_val), 32'd0);
    chk("rst_accum", 32'(accum_en), 32'd0);
    chk("rst_addr", 32'(filt_rdaddr), 32'd0);
    chk("rst_tap", 32'(filt_tap), 32'd0);
    chk("rst_ch", 32'(img_ch), 32'd0);
    chk("rst_grp", 32'(grp), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_job_rdy", 32'(job_rdy), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Job 1: single-cycle request; first pass has pass_done 6 cycles after the
    // handshake (cycle 10), third pass sees 5 cycles of backpressure.
    job_val = 1'b1;
    chk("job1_accept_rdy", 32'(job_rdy), 32'd1);
    step();
    job_val = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++)
      for (int c = 0; c < IMG_D; c++)
        run_pass(g, c, (g == 0 && c == 0) ? 6 : 2, (g == 0 && c == 2) ? 5 : 0, 0);
    chk("job1_done", 32'(done), 32'd1);
    chk("job1_done_busy", 32'(busy), 32'd1);
    step();
    chk("job1_after_done", 32'(done), 32'd0);
    chk("job1_idle_rdy", 32'(job_rdy), 32'd1);
    chk("job1_idle_busy", 32'(busy), 32'd0);
    chk("job1_idle_accum", 32'(accum_en), 32'd0);
    chk("job1_done_count", 32'(done_cnt), 32'd1);

    // Job 2: job_val held high throughout, spurious pass_done in one LOAD.
    job_val = 1'b1;
    step();
    for (int g = 0; g < NUM_GROUPS; g++)
      for (int c = 0; c < IMG_D; c++)
        run_pass(g, c, (c == 1) ? 4 : 1, 0, (g == 1 && c == 1) ? 1 : 0);
    chk("job2_done", 32'(done), 32'd1);
    step();
    // Back-to-back: job_val still high in the cycle after done.
    chk("b2b_idle_rdy", 32'(job_rdy), 32'd1);
    chk("b2b_idle_done", 32'(done), 32'd0);
    step();
    job_val = 1'b0;
    chk("b2b_load_busy", 32'(busy), 32'd1);
    chk("b2b_load_addr", 32'(filt_rdaddr), 32'd0);
    chk("b2b_load_ch", 32'(img_ch), 32'd0);
    chk("b2b_load_grp", 32'(grp), 32'd0);
    chk("b2b_load_accum", 32'(accum_en), 32'd0);
    step();
    chk("b2b_load2_addr", 32'(filt_rdaddr), 32'd1);
    chk("b2b_load2_wren", 32'(filt_wren), 32'd1);

    // Reset mid-LOAD aborts without a done pulse.
    reset = 1'b1;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_job_rdy", 32'(job_rdy), 32'd1);
    chk("abort_wren", 32'(filt_wren), 32'd0);
    chk("abort_addr", 32'(filt_rdaddr), 32'd0);
    chk("abort_tap", 32'(filt_tap), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) step();
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_done_count", 32'(done_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
